// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Asynchronous 8N1-style serial receiver. Synchronizes uart_rxd, detects the
//   start bit, samples PAYLOAD_BITS data bits LSB first at mid-bit and checks
//   the first stop bit. A good frame loads uart_rx_data and pulses
//   uart_rx_valid. A frame with every data bit low and a low stop bit pulses
//   uart_rx_break instead.
//
// Ports
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   uart_rxd       asynchronous serial line, idle high
//   uart_rx_en     receive enable; low aborts any frame in progress
//   uart_rx_break  one-cycle pulse, BREAK frame received
//   uart_rx_valid  one-cycle pulse, new byte on uart_rx_data
//   uart_rx_data   last good byte, held until the next good frame
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN  when defined, each sample is the 2-of-3 majority
//                             of rxd_s around the mid-bit point. The decision
//                             is taken at the later of the three points.
module uart_rx_core #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int CYCLES_PER_BIT    = CLK_HZ / BIT_RATE;
    localparam int SAMPLES_THRESHOLD = CYCLES_PER_BIT / 2;
    localparam int CNT_W             = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W             = $clog2(PAYLOAD_BITS + 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int SAMPLE_AT = SAMPLES_THRESHOLD + 1;
`else
    localparam int SAMPLE_AT = SAMPLES_THRESHOLD;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        RECV,
        STOP
    } state_t;

    state_t                  state;
    logic                    rxd_m;
    logic                    rxd_s;
    logic                    sample;
    logic                    stop_ok;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [PAYLOAD_BITS-1:0] shreg;

    // Two-flop synchronizer, idle-high reset value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rxd_d1;
    logic rxd_d2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_d1 <= 1'b1;
            rxd_d2 <= 1'b1;
        end else begin
            rxd_d1 <= rxd_s;
            rxd_d2 <= rxd_d1;
        end
    end

    // Decision cycle is threshold+1, so rxd_d2/rxd_d1/rxd_s are the
    // threshold-1/threshold/threshold+1 values.
    always_comb begin
        sample = (rxd_s & rxd_d1) | (rxd_s & rxd_d2) | (rxd_d1 & rxd_d2);
    end
`else
    always_comb begin
        sample = rxd_s;
    end
`endif

    // With no stop bits configured there is nothing to check.
    always_comb begin
        stop_ok = (STOP_BITS == 0) || sample;
    end

    // The counter holds (cycles since state entry - 1) at each edge, so
    // comparing against N-1 acts exactly N cycles after entry.
    // Data bits shift in from the MSB end. After PAYLOAD_BITS shifts, the
    // first bit received sits in bit 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            if (!uart_rx_en) begin
                state <= IDLE;
                cnt   <= '0;
                idx   <= '0;
                shreg <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == CNT_W'(SAMPLE_AT - 1)) begin
                            cnt <= '0;
                            if (!sample) begin
                                state <= RECV;
                                idx   <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RECV: begin
                        if (cnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
                            cnt   <= '0;
                            shreg <= {sample, shreg[PAYLOAD_BITS-1:1]};
                            if (idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                                state <= STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == CNT_W'(CYCLES_PER_BIT - 1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                            if (stop_ok) begin
                                uart_rx_data  <= shreg;
                                uart_rx_valid <= 1'b1;
                            end else if (shreg == '0) begin
                                uart_rx_break <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int CLK_HZ   = 50000000;
    localparam int BIT_RATE = 3000000;
    localparam int C        = CLK_HZ / BIT_RATE;   // 16 cycles per bit
    localparam int T        = C / 2;               // mid-bit threshold
    // Start edge driven -> strobe visible: 3 sync/detect, T to the start
    // check, 9 bit periods to the stop sample, then the strobe shows up.
    localparam int LAT      = 3 + T + 9 * C;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b0;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    always #10 clk = ~clk;

    uart_rx_core #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          brk;
        logic [7:0]  data;
        int unsigned at;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        cur_e;
    logic [7:0] model_data = 8'h00;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (resetn && (uart_rx_valid || uart_rx_break)) begin
            check_val("exclusive", 32'(uart_rx_valid & uart_rx_break), 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 32'({uart_rx_break, uart_rx_valid}), 32'd0);
            end else begin
                cur_e = exp_q.pop_front();
                check_val("strobe_kind", 32'(uart_rx_break), 32'(cur_e.brk));
                check_val("strobe_cycle", cyc, cur_e.at);
                if (!cur_e.brk) begin
                    check_val("rx_data", 32'(uart_rx_data), 32'(cur_e.data));
                    model_data = cur_e.data;
                end else begin
                    check_val("break_data", 32'(uart_rx_data), 32'(model_data));
                end
            end
        end
    end

    // Drive one frame. When expect_ev is set, the model records what the
    // receiver should report: good stop -> byte, low stop with zero data ->
    // break, otherwise nothing.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input bit expect_ev);
        logic [7:0]  bits;
        int unsigned t0;
        ev_t         e;
        @(negedge clk);
        uart_rxd = 1'b0;
        t0 = cyc;
        if (expect_ev) begin
            e.data = d;
            e.at   = t0 + LAT;
            if (stop) begin
                e.brk = 1'b0;
                exp_q.push_back(e);
            end else if (d == 8'h00) begin
                e.brk = 1'b1;
                exp_q.push_back(e);
            end
        end
        repeat (C) @(negedge clk);
        bits = d;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = bits[0];
            bits = bits >> 1;
            repeat (C) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (C) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_valid", 32'(uart_rx_valid), 32'd0);
        check_val("rst_break", 32'(uart_rx_break), 32'd0);
        check_val("rst_data", 32'(uart_rx_data), 32'd0);
        resetn = 1'b1;
        uart_rx_en = 1'b1;
        repeat (2 * C) @(negedge clk);

        // Single known byte
        send_frame(8'hA5, 1'b1, 50, 1'b1);
        check_val("a5_pending", 32'(exp_q.size()), 32'd0);
        check_val("a5_data", 32'(uart_rx_data), 32'h0000_00A5);

        // Random bytes, gaps from back-to-back up to about 1 us
        for (int n = 0; n < 100; n++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b1, int'($urandom_range(0, 50)), 1'b1);
        end
        check_val("burst_pending", 32'(exp_q.size()), 32'd0);
        check_val("burst_data", 32'(uart_rx_data), 32'(model_data));

        // Break after a known byte: data must keep 0xA5
        send_frame(8'hA5, 1'b1, 50, 1'b1);
        send_frame(8'h00, 1'b0, 2 * C, 1'b1);
        check_val("break_pending", 32'(exp_q.size()), 32'd0);
        check_val("break_hold", 32'(uart_rx_data), 32'h0000_00A5);

        // Short low glitch on the idle line, then a normal frame
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (C) @(negedge clk);
        check_val("glitch_hold", 32'(uart_rx_data), 32'h0000_00A5);
        send_frame(8'h5A, 1'b1, 20, 1'b1);
        check_val("glitch_next", 32'(uart_rx_data), 32'h0000_005A);

        // Enable dropped mid-frame, then the same byte with enable held high
        fork
            send_frame(8'h3C, 1'b1, C, 1'b0);
            begin
                repeat (4 * C) @(negedge clk);
                uart_rx_en = 1'b0;
            end
        join
        uart_rx_en = 1'b1;
        repeat (C) @(negedge clk);
        check_val("en_drop_hold", 32'(uart_rx_data), 32'h0000_005A);
        send_frame(8'h3C, 1'b1, 20, 1'b1);
        check_val("en_next", 32'(uart_rx_data), 32'h0000_003C);

        // Reset asserted during data bit 4
        fork
            send_frame(8'hFF, 1'b1, C, 1'b0);
            begin
                repeat (5 * C + T) @(negedge clk);
                resetn = 1'b0;
                #1;
                check_val("midrst_valid", 32'(uart_rx_valid), 32'd0);
                check_val("midrst_break", 32'(uart_rx_break), 32'd0);
                check_val("midrst_data", 32'(uart_rx_data), 32'd0);
            end
        join
        model_data = 8'h00;
        resetn = 1'b1;
        repeat (C) @(negedge clk);
        send_frame(8'h81, 1'b1, 20, 1'b1);
        check_val("post_rst", 32'(uart_rx_data), 32'h0000_0081);

        // Random frames with random stop bits (framing errors, breaks)
        for (int n = 0; n < 20; n++) begin
            rb = (n % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            send_frame(rb, rs, rs ? int'($urandom_range(0, 30)) : 2 * C, 1'b1);
        end

        repeat (3 * C) @(negedge clk);
        check_val("final_pending", 32'(exp_q.size()), 32'd0);
        check_val("final_data", 32'(uart_rx_data), 32'(model_data));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
